// File: rtl/nios_uart_onchip_pkg.sv
// Shared types, constants and elaboration helpers for the pipelined on-chip RAM.
package nios_uart_onchip_pkg;

    localparam int MAX_READ_LATENCY = 3;

    typedef enum logic {CLEAR, RUN} state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit params_ok(input int dw, input int rl);
        return (dw > 0) && (dw % 8 == 0) && (rl >= 1) && (rl <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/nios_uart_onchip_ram_core.sv
// Byte-enabled single-port RAM with a clock-enabled synchronous read register.
// Initial contents come from INIT_FILE through the synthesis tool's RAM init attribute.
module nios_uart_onchip_ram_core
    import nios_uart_onchip_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    DEPTH      = 1024,
    parameter string INIT_FILE  = "onchip_mem.hex",
    localparam int   AW         = clog2(DEPTH),
    localparam int   BE_W       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  we,
    input  logic                  re,
    input  logic                  zero_rd,
    input  logic [AW-1:0]         addr,
    input  logic [BE_W-1:0]       be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    if (INIT_FILE == "") begin : g_bad_init
        $error("nios_uart_onchip_ram_core: INIT_FILE must name a memory image");
    end

    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ce && we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Out-of-range reads load zero instead of touching the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (ce && re) begin
            q <= zero_rd ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/nios_uart_onchip_ram_pipe.sv
// Avalon-MM pipelined-read on-chip RAM: handshake, read pipeline, error flag, clear sequencer.
// Defining ONCHIP_RAM_CLEAR_EN zero-fills the array after every reset.
module nios_uart_onchip_ram_pipe
    import nios_uart_onchip_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH        = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "onchip_mem.hex",
    localparam int   AW           = clog2(DEPTH),
    localparam int   BE_W         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         address,
    input  logic [BE_W-1:0]       byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic                  clken,
    input  logic                  reset_req,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_busy,
    output logic                  err_oor
);

    if (!params_ok(DATA_WIDTH, READ_LATENCY)) begin : g_bad_params
        $error("nios_uart_onchip_ram_pipe: illegal DATA_WIDTH or READ_LATENCY");
    end

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic                    en, accept, wr_acc, rd_acc, in_range;
    logic [READ_LATENCY-1:0] vld;
    logic [DATA_WIDTH-1:0]   core_q, core_wdata;
    logic [AW-1:0]           core_addr;
    logic [BE_W-1:0]         core_be;
    logic                    core_we;

    assign en          = clken & ~reset_req;
    assign waitrequest = ~en | init_busy;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & read & ~write;
    assign in_range    = ({1'b0, address} < DEPTH_W);

`ifdef ONCHIP_RAM_CLEAR_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] clr_addr;
    logic          clearing;

    // One zero word per enabled cycle; the last write hands over to RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_busy <= 1'b1;
        end else if (state == CLEAR && en) begin
            if (clr_addr == LAST_ADDR) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end else begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    assign clearing   = (state == CLEAR);
    assign core_addr  = clearing ? clr_addr : address;
    assign core_we    = clearing | (wr_acc & in_range);
    assign core_be    = clearing ? '1 : byteenable;
    assign core_wdata = clearing ? '0 : writedata;
`else
    assign init_busy  = 1'b0;
    assign core_addr  = address;
    assign core_we    = wr_acc & in_range;
    assign core_be    = byteenable;
    assign core_wdata = writedata;
`endif

    nios_uart_onchip_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_FILE  (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .ce      (en),
        .we      (core_we),
        .re      (rd_acc),
        .zero_rd (~in_range),
        .addr    (core_addr),
        .be      (core_be),
        .wdata   (core_wdata),
        .q       (core_q)
    );

    // Valid bits only move on enabled cycles, so a stall freezes every read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else if (en) begin
            vld <= (vld << 1) | READ_LATENCY'(rd_acc);
        end
    end

    assign readdatavalid = vld[READ_LATENCY-1] & en;

    if (READ_LATENCY == 1) begin : g_direct
        assign readdata = core_q;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] pipe_q [1:READ_LATENCY-1];

        // Stages load only behind a valid entry so readdata holds between reads.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= '0;
            end else if (en) begin
                if (vld[0]) pipe_q[1] <= core_q;
                for (int i = 2; i < READ_LATENCY; i++) begin
                    if (vld[i-1]) pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign readdata = pipe_q[READ_LATENCY-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_oor <= 1'b0;
        end else if (accept && !in_range) begin
            err_oor <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios_uart_onchip_ram_pipe.sv
// Randomised and directed bench for nios_uart_onchip_ram_pipe against a queue-based read model.
// Builds with or without ONCHIP_RAM_CLEAR_EN (DEPTH shrinks to 16 when the clear is enabled).
module tb_nios_uart_onchip_ram_pipe;
    import nios_uart_onchip_pkg::*;

    localparam int DW = 32;
    localparam int RL = 2;
`ifdef ONCHIP_RAM_CLEAR_EN
    localparam int DEPTH = 16;
    localparam bit CLEAR_BUILD = 1'b1;
`else
    localparam int DEPTH = 1000;
    localparam bit CLEAR_BUILD = 1'b0;
`endif
    localparam int AW   = clog2(DEPTH);
    localparam int WORK = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect, read, write, clken, reset_req;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          readdatavalid, waitrequest, init_busy, err_oor;

    nios_uart_onchip_ram_pipe #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .INIT_FILE    ("onchip_mem.hex")
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .reset_req     (reset_req),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .init_busy     (init_busy),
        .err_oor       (err_oor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            age;
    } rd_t;

    logic [DW-1:0] mem_model [DEPTH];
    rd_t           pend [$];
    logic [DW-1:0] last_data;
    bit            err_model;
    int            clear_left;
    int            checks = 0;
    int            errors = 0;
    logic          obs_rdv, obs_wait, obs_busy;
    logic [DW-1:0] obs_rdata;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic applyStimulus(input logic cs, input logic rd, input logic wr, input int a,
                                 input logic [3:0] be, input logic [DW-1:0] wd,
                                 input logic ck, input logic rr);
        bit  en_m, acc, exp_rdv;
        rd_t e;
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = AW'(a);
        byteenable = be;
        writedata  = wd;
        clken      = ck;
        reset_req  = rr;
        @(negedge clk);
        en_m    = ck && !rr;
        exp_rdv = en_m && pend.size() > 0 && pend[0].age == RL - 1;
        checkOutput("readdatavalid", 32'(readdatavalid), 32'(exp_rdv));
        checkOutput("readdata", readdata, last_data);
        checkOutput("waitrequest", 32'(waitrequest), 32'(!en_m || clear_left > 0));
        checkOutput("err_oor", 32'(err_oor), 32'(err_model));
        checkOutput("init_busy", 32'(init_busy), 32'(clear_left > 0));
        obs_rdv   = readdatavalid;
        obs_wait  = waitrequest;
        obs_busy  = init_busy;
        obs_rdata = readdata;
        @(posedge clk);
        acc = cs && (rd || wr) && en_m && clear_left == 0;
        if (en_m) begin
            if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
                end
            end
            if (pend.size() > 0 && pend[0].age == RL - 1) void'(pend.pop_front());
            foreach (pend[i]) begin
                pend[i].age++;
                if (pend[i].age == RL - 1) last_data = pend[i].data;
            end
        end
        if (acc) begin
            if (a >= DEPTH) err_model = 1'b1;
            if (wr) begin
                if (a < DEPTH) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mem_model[a][b*8 +: 8] = wd[b*8 +: 8];
                    end
                end
            end else begin
                e.data = (a < DEPTH) ? mem_model[a] : '0;
                e.age  = 0;
                if (RL == 1) last_data = e.data;
                pend.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ck);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 4'h0, '0, ck, 1'b0);
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
        applyStimulus(1'b1, 1'b0, 1'b1, a, be, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input int a);
        applyStimulus(1'b1, 1'b1, 1'b0, a, 4'h0, '0, 1'b1, 1'b0);
    endtask

    task automatic doReset(input int hold);
        reset      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        clken      = 1'b1;
        reset_req  = 1'b0;
        pend.delete();
        last_data  = '0;
        err_model  = 1'b0;
        clear_left = CLEAR_BUILD ? DEPTH : 0;
        @(negedge clk);
        checkOutput("rst_readdatavalid", 32'(readdatavalid), 32'h0);
        checkOutput("rst_readdata", readdata, 32'h0);
        checkOutput("rst_err_oor", 32'(err_oor), 32'h0);
        checkOutput("rst_init_busy", 32'(init_busy), 32'(CLEAR_BUILD));
        repeat (hold) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        address = '0; byteenable = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; clken = 1'b1; reset_req = 1'b0;
        @(posedge clk);
        #1;
        doReset(2);

`ifdef ONCHIP_RAM_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b1);
            checkOutput("clear_busy", 32'(obs_busy), 32'h1);
            checkOutput("clear_wait", 32'(obs_wait), 32'h1);
        end
        idle(1'b1);
        checkOutput("clear_done", 32'(obs_busy), 32'h0);
        for (int a = 0; a < DEPTH; a++) rd(a);
        repeat (RL + 1) idle(1'b1);
        doReset(1);
        repeat (8) idle(1'b1);
        doReset(1);
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b1);
            checkOutput("restart_busy", 32'(obs_busy), 32'h1);
        end
        idle(1'b1);
        checkOutput("restart_done", 32'(obs_busy), 32'h0);
`endif

        wr(5, 32'hDEADBEEF, 4'hF);
        rd(5);
        idle(1'b1);
        checkOutput("t1_early", 32'(obs_rdv), 32'h0);
        idle(1'b1);
        checkOutput("t1_pulse", 32'(obs_rdv), 32'h1);
        checkOutput("t1_data", obs_rdata, 32'hDEADBEEF);
        idle(1'b1);
        checkOutput("t1_single", 32'(obs_rdv), 32'h0);

        wr(7, 32'h11223344, 4'hF);
        wr(7, 32'hAABBCCDD, 4'b0101);
        rd(7);
        idle(1'b1);
        idle(1'b1);
        checkOutput("t2_pulse", 32'(obs_rdv), 32'h1);
        checkOutput("t2_data", obs_rdata, 32'h11BB33DD);

        wr(3, 32'hCAFEF00D, 4'hF);
        rd(3);
        idle(1'b1);
        idle(1'b1);
        checkOutput("t3_raw", obs_rdata, 32'hCAFEF00D);

        wr(10, 32'h0BADC0DE, 4'hF);
        rd(10);
        idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            checkOutput("t4_stall_wait", 32'(obs_wait), 32'h1);
            checkOutput("t4_stall_rdv", 32'(obs_rdv), 32'h0);
            checkOutput("t4_stall_data", obs_rdata, 32'h0BADC0DE);
        end
        idle(1'b1);
        checkOutput("t4_resume_rdv", 32'(obs_rdv), 32'h1);

`ifndef ONCHIP_RAM_CLEAR_EN
        wr(1000, 32'h12345678, 4'hF);
        rd(1000);
        idle(1'b1);
        idle(1'b1);
        checkOutput("t5_oor_rdv", 32'(obs_rdv), 32'h1);
        checkOutput("t5_oor_data", obs_rdata, 32'h0);
        checkOutput("t5_err", 32'(err_oor), 32'h1);
        rd(5);
        idle(1'b1);
        idle(1'b1);
        checkOutput("t5_array_intact", obs_rdata, 32'hDEADBEEF);
        checkOutput("t5_err_sticky", 32'(err_oor), 32'h1);
        doReset(1);
`endif

        rd(5);
        doReset(1);
        for (int i = 0; i < RL + 1; i++) begin
            idle(1'b1);
            checkOutput("t6_no_pulse", 32'(obs_rdv), 32'h0);
        end
`ifdef ONCHIP_RAM_CLEAR_EN
        repeat (DEPTH) idle(1'b1);
`endif

        for (int a = 0; a < WORK; a++) wr(a, $urandom, 4'hF);
        for (int n = 0; n < 1500; n++) begin
            int  op, a;
            if ($urandom % 250 == 0) begin
                doReset(1);
            end else begin
                op = int'($urandom % 4);
                if (!CLEAR_BUILD && $urandom % 16 == 0) a = 1000 + int'($urandom % 24);
                else a = int'($urandom % WORK);
                applyStimulus(1'(($urandom % 8) != 0), 1'(op == 0 || op == 2),
                              1'(op == 1 || op == 2), a, 4'($urandom), $urandom,
                              1'(($urandom % 6) != 0), 1'(($urandom % 10) == 0));
            end
        end
        repeat (RL + 2) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
